// File: rtl/alu_instr_seq_if.sv
// Host / instruction-unit signal bundle for alu_instr_seq.
// master = host + instruction unit side, slave = the sequencer itself.
interface alu_instr_seq_if #(
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic               prog_we;
  logic [INSTR_W-1:0] prog_wdata;
  logic               prog_full;
  logic               prog_empty;
  logic [CNT_W-1:0]   prog_count;
  logic               run;
  logic               clear;
  logic [INSTR_W-1:0] instr;
  logic               done;
  logic [15:0]        result;
  logic               busy;
  logic               res_valid;
  logic               res_ready;
  logic [15:0]        res_data;
  logic [15:0]        retired;
  logic               overflow;
  logic               err;

  modport master (
    output prog_we, prog_wdata, run, clear, done, result, res_ready,
    input  prog_full, prog_empty, prog_count, instr, busy,
           res_valid, res_data, retired, overflow, err
  );

  modport slave (
    input  prog_we, prog_wdata, run, clear, done, result, res_ready,
    output prog_full, prog_empty, prog_count, instr, busy,
           res_valid, res_data, retired, overflow, err
  );
endinterface

// File: rtl/alu_instr_seq.sv
// Instruction sequencer: program FIFO -> instr/done issue FSM -> valid/ready result port.
// Optional watchdog + ERR state built when SEQ_TIMEOUT_EN is defined.
module alu_instr_seq #(
  parameter int                 INSTR_W  = 32,
  parameter int                 DEPTH    = 16,
  parameter logic [INSTR_W-1:0] NOP_WORD = '0,
  parameter int                 TIMEOUT  = 255
) (
  input  logic           clk,
  input  logic           reset,
  alu_instr_seq_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

`ifdef SEQ_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ISSUE = 3'd1, S_WAIT = 3'd2, S_RETIRE = 3'd3, S_ERR = 3'd4
  } state_t;
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_reg;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_RETIRE = 2'd3
  } state_t;
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]      count_reg;
  state_t             state_reg, state_next;
  logic [INSTR_W-1:0] instr_reg;
  logic [15:0]        cap_reg, res_data_reg, retired_reg;
  logic               pending_reg, res_valid_reg, overflow_reg;
  logic               full, empty, push, pop, slot_free;
  logic               complete, load_now, load_cap;

  assign full      = (count_reg == CW'(DEPTH));
  assign empty     = (count_reg == '0);
  assign push      = bus.prog_we && !bus.clear && !full;
  assign slot_free = !res_valid_reg || bus.res_ready;
  assign load_now  = complete && slot_free;

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    complete   = 1'b0;
    load_cap   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!bus.clear && bus.run && !empty) begin
          pop        = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE, S_WAIT: begin
        if (bus.done) begin
          complete   = 1'b1;
          state_next = S_RETIRE;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (wd_reg == WD_W'(TIMEOUT)) state_next = S_ERR;
`endif
        else state_next = S_WAIT;
      end
      S_RETIRE: begin
        // Result may already have gone straight to the slot on done; otherwise wait for room.
        if (!pending_reg) begin
          state_next = S_IDLE;
        end else if (slot_free) begin
          load_cap   = 1'b1;
          state_next = S_IDLE;
        end
      end
`ifdef SEQ_TIMEOUT_EN
      S_ERR: if (bus.clear) state_next = S_IDLE;
`endif
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= bus.prog_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      instr_reg     <= NOP_WORD;
      cap_reg       <= '0;
      pending_reg   <= 1'b0;
      res_data_reg  <= '0;
      res_valid_reg <= 1'b0;
      retired_reg   <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (bus.clear) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        count_reg <= count_reg + CW'(push) - CW'(pop);
      end

      if (pop)
        instr_reg <= mem[rd_ptr_reg];
      else if (state_next != S_ISSUE && state_next != S_WAIT)
        instr_reg <= NOP_WORD;

      if (complete) begin
        cap_reg     <= bus.result;
        pending_reg <= !slot_free;
      end else if (load_cap) begin
        pending_reg <= 1'b0;
      end

      if (load_now || load_cap) begin
        res_data_reg  <= load_now ? bus.result : cap_reg;
        res_valid_reg <= 1'b1;
        retired_reg   <= retired_reg + 16'd1;
      end else if (bus.res_ready) begin
        res_valid_reg <= 1'b0;
      end

      if (bus.clear)
        overflow_reg <= 1'b0;
      else if (bus.prog_we && full)
        overflow_reg <= 1'b1;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  // Counts cycles spent in ISSUE+WAIT for the current instruction.
  always_ff @(posedge clk) begin
    if (reset || pop)
      wd_reg <= '0;
    else if (state_reg == S_ISSUE || state_reg == S_WAIT)
      wd_reg <= wd_reg + 1'b1;
  end
  assign bus.err = (state_reg == S_ERR);
`else
  assign bus.err = 1'b0;
`endif

  assign bus.prog_full  = full;
  assign bus.prog_empty = empty;
  assign bus.prog_count = count_reg;
  assign bus.instr      = instr_reg;
  assign bus.busy       = (state_reg == S_ISSUE) || (state_reg == S_WAIT) ||
                          (state_reg == S_RETIRE);
  assign bus.res_valid  = res_valid_reg;
  assign bus.res_data   = res_data_reg;
  assign bus.retired    = retired_reg;
  assign bus.overflow   = overflow_reg;
endmodule

// File: doc/alu_instr_seq.md
# alu_instr_seq

Instruction sequencer for the ALU/memory-interface/instruction-unit datapath: the issuing end of the instruction-unit `instr`/`done` interface. A host loads instruction words into an internal program FIFO; the sequencer presents them one at a time on `instr`, holds each until the instruction unit pulses `done`, captures the 16-bit `result`, and hands it to the host over a valid/ready port. It sits between a testbench or host controller and the datapath top, replacing hand-driven `instr` stimulus.

## Interface
- `INSTR_W`, 32: width of one instruction word; matches the packed width of `instruction_t`.
- `DEPTH`, 16: program FIFO entries; power of two, at least 2.
- `NOP_WORD`, 0: word driven on `instr` whenever no instruction is in flight.
- `TIMEOUT`, 255: watchdog limit in cycles; only used with `SEQ_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `prog_we`  in  1  push `prog_wdata` into the program FIFO.
- `prog_wdata`  in  INSTR_W  instruction word to load.
- `prog_full`  out  1  FIFO holds DEPTH entries.
- `prog_empty`  out  1  FIFO holds 0 entries.
- `prog_count`  out  $clog2(DEPTH+1)  current FIFO occupancy.
- `run`  in  1  level; while high, the sequencer issues queued instructions.
- `clear`  in  1  one-cycle pulse; flushes the FIFO and clears the sticky flags.
- `instr`  out  INSTR_W  registered instruction to the instruction unit.
- `done`  in  1  instruction-unit completion pulse.
- `result`  in  16  instruction-unit result, valid with `done`.
- `busy`  out  1  instruction in flight (ISSUE, WAIT or RETIRE).
- `res_valid`  out  1  `res_data` holds an unconsumed result.
- `res_ready`  in  1  host accepts `res_data`.
- `res_data`  out  16  captured result.
- `retired`  out  16  count of retired instructions; wraps from 0xFFFF to 0.
- `overflow`  out  1  sticky flag: a push was attempted while the FIFO was full.
- `err`  out  1  sticky flag: watchdog expired.

## Operation
- Reset values: `instr`=NOP_WORD, `busy`=0, `prog_empty`=1, `prog_full`=0, `prog_count`=0, `res_valid`=0, `res_data`=0, `retired`=0, `overflow`=0, `err`=0. The state machine goes to IDLE and the FIFO pointers go to 0.
- FIFO:
  - Circular buffer with wrap-around read/write pointers.
  - A push when full is dropped and sets `overflow`; FIFO contents are unchanged.
  - A push and a pop in the same cycle are both honoured and the count is unchanged.
  - A push to an empty FIFO while `run` is high is visible to IDLE one cycle later.
- State machine:
  - IDLE: `instr`=NOP_WORD. If `run` is high and the FIFO is not empty, pop the head into the `instr` register and go to ISSUE.
  - ISSUE: hold `instr` for 1 cycle, then go to WAIT. If `done` is sampled high here, treat it as WAIT completion.
  - WAIT: hold `instr` until `done`. On `done`, capture `result` and go to RETIRE.
  - RETIRE: `instr`=NOP_WORD.
    - If the result slot is free, or is being consumed this cycle (`res_valid`&&`res_ready`): load `res_data`, set `res_valid`, increment `retired`, go to IDLE.
    - Otherwise stay in RETIRE (back-pressure) holding the captured result.
  - ERR (`SEQ_TIMEOUT_EN` only): `instr`=NOP_WORD, `busy`=0, `err`=1. Stays in ERR until `clear`.
- `run` deasserted mid-instruction: the current instruction completes and retires; no new issue.
- `done` outside ISSUE/WAIT is ignored.
- Result port: `res_valid` drops the cycle after a handshake unless RETIRE reloads it in the same cycle.
- `clear`:
  - Empties the FIFO and clears `overflow` and `err`.
  - Forces IDLE, except when in ISSUE/WAIT/RETIRE. In those states the in-flight instruction still completes and retires.
  - Leaves `retired` and the result slot untouched.
  - If `clear` and `prog_we` arrive together, `clear` wins and the push is dropped.
- Reset mid-operation: all state returns to reset values at the next edge; the in-flight result is discarded.

## Timing
- `run` rises at edge 0 with a non-empty FIFO: `instr` carries the word from edge 1 (ISSUE), `busy`=1.
- `done` sampled at edge n: RETIRE at n+1, `res_valid`=1 and `instr`=NOP_WORD from n+1, IDLE at n+2.
- Minimum issue period is 3 cycles (IDLE→ISSUE→RETIRE→IDLE, with `done` in ISSUE).
- The instruction unit sees NOP_WORD for at least 1 cycle between instructions.
- Watchdog: counts cycles in ISSUE+WAIT. Reaching TIMEOUT without `done` enters ERR on the next edge.

## Configuration
- `SEQ_TIMEOUT_EN` defined: watchdog counter, ERR state and `err` flag are built as described.
- `SEQ_TIMEOUT_EN` undefined: no counter and no ERR state; WAIT waits indefinitely. `err` is tied to 0 and TIMEOUT is unused.

## Test plan
- Load 3 words (0x11, 0x22, 0x33), hold `run`=1, `res_ready`=1, reply `done` 4 cycles after each issue with results 0x0001/0x0002/0x0003 -> `instr` shows 0x11, 0x22, 0x33 in order with NOP_WORD gaps; results arrive in order; `retired`=3; `prog_empty`=1.
- Push 17 words into DEPTH=16 -> `prog_full`=1, `prog_count`=16, `overflow`=1. Draining returns the first 16 words only.
- `res_ready`=0 with two queued instructions -> first result held in `res_data`; sequencer stalls in RETIRE after the second `done`. Asserting `res_ready` delivers both, in order.
- `done` asserted in the ISSUE cycle -> RETIRE on the next edge; 3-cycle period achieved.
- With `SEQ_TIMEOUT_EN`, TIMEOUT=8, `done` never asserted -> `err`=1 at cycle 9 after issue, `instr`=NOP_WORD. `clear` returns to IDLE with `err`=0.
- `reset` asserted while in WAIT with 5 entries queued -> next cycle every output equals its reset value and `prog_count`=0.
